// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - rectangle/clear fill engine feeding the VGA frame-buffer write port
// Normalises and clips each command, then scans it row-major at one pixel per clock.
module vga_rect_fill #(
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int COORD_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_clear_i,
  input  logic [COORD_BITS-1:0] x0_i,
  input  logic [COORD_BITS-1:0] y0_i,
  input  logic [COORD_BITS-1:0] x1_i,
  input  logic [COORD_BITS-1:0] y1_i,
  input  logic [1:0]            color_i,
  output logic                  we_o,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic [1:0]            color_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(HD - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(VD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [COORD_BITS-1:0] xa_q, xa_d, xb_q, xb_d, yb_q, yb_d;
  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]            color_q, color_d;

  logic [COORD_BITS-1:0] lo_x, hi_x, lo_y, hi_y;
  logic [COORD_BITS-1:0] cx_a, cx_b, cy_a, cy_b;
  logic                  cmd_empty;

  // Rectangle as it would be stored if accepted this cycle.
  always_comb begin
    lo_x = (x0_i < x1_i) ? x0_i : x1_i;
    hi_x = (x0_i < x1_i) ? x1_i : x0_i;
    lo_y = (y0_i < y1_i) ? y0_i : y1_i;
    hi_y = (y0_i < y1_i) ? y1_i : y0_i;
    if (cmd_clear_i) begin
      cx_a = '0;
      cy_a = '0;
      cx_b = X_MAX;
      cy_b = Y_MAX;
    end else begin
      cx_a = lo_x;
      cy_a = lo_y;
      cx_b = (hi_x > X_MAX) ? X_MAX : hi_x;
      cy_b = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    end
    cmd_empty = (cx_a > X_MAX) || (cy_a > Y_MAX);
  end

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_empty) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
            xa_d    = cx_a;
            xb_d    = cx_b;
            yb_d    = cy_b;
            x_d     = cx_a;
            y_d     = cy_a;
            color_d = color_i;
          end
        end
      end
      ST_FILL: begin
        // Address registers stay on the last pixel once the scan ends.
        if (x_q == xb_q) begin
          if (y_q == yb_q) begin
            state_d = ST_DONE;
          end else begin
            x_d = xa_q;
            y_d = y_q + COORD_BITS'(1);
          end
        end else begin
          x_d = x_q + COORD_BITS'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xa_q    <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign we_o        = (state_q == ST_FILL);
  assign done_o      = (state_q == ST_DONE);
  assign addr_x_o    = x_q;
  assign addr_y_o    = y_q;
  assign color_o     = color_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - scoreboard bench for vga_rect_fill
// Reduced display size keeps the clear command short.
module tb_vga_rect_fill;
  localparam int HD = 64;
  localparam int VD = 48;
  localparam int CB = 11;

  logic          clk = 0;
  logic          rst = 1;
  logic          cmd_valid_i = 0;
  logic          cmd_ready_o;
  logic          cmd_clear_i = 0;
  logic [CB-1:0] x0_i = 0, y0_i = 0, x1_i = 0, y1_i = 0;
  logic [1:0]    color_i = 0;
  logic          we_o;
  logic [CB-1:0] addr_x_o, addr_y_o;
  logic [1:0]    color_o;
  logic          busy_o, done_o;

  vga_rect_fill #(.HD(HD), .VD(VD), .COORD_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_clear_i(cmd_clear_i),
    .x0_i(x0_i), .y0_i(y0_i), .x1_i(x1_i), .y1_i(y1_i), .color_i(color_i),
    .we_o(we_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .color_o(color_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit dn; int x; int y; int c; int cy; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected writes from the plain rectangle rules, stamped with their cycles.
  task automatic model_push(input bit clr, input int x0, input int y0, input int x1,
                            input int y1, input int col, input int acc);
    int xa, xb, ya, yb, k;
    if (clr) begin
      xa = 0; ya = 0; xb = HD - 1; yb = VD - 1;
    end else begin
      xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
      ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
      if (xb > HD - 1) xb = HD - 1;
      if (yb > VD - 1) yb = VD - 1;
    end
    k = 0;
    if (xa <= HD - 1 && ya <= VD - 1)
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++) begin
          exp_q.push_back('{dn: 0, x: x, y: y, c: col, cy: acc + k});
          k++;
        end
    exp_q.push_back('{dn: 1, x: 0, y: 0, c: 0, cy: acc + k});
  endtask

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input bit clr, input int x0, input int y0, input int x1,
                      input int y1, input int col, input bit hold);
    bit r, got;
    cmd_valid_i = 1; cmd_clear_i = clr;
    x0_i = CB'(x0); y0_i = CB'(y0); x1_i = CB'(x1); y1_i = CB'(y1); color_i = 2'(col);
    got = 0;
    for (int t = 0; t < 5000 && !got; t++) begin
      @(negedge clk); r = cmd_ready_o;
      @(posedge clk); #1;
      if (r) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else begin
      last_acc = cyc;
      model_push(clr, x0, y0, x1, y1, col, cyc);
    end
    if (!hold) cmd_valid_i = 0;
    x0_i = CB'($urandom); y0_i = CB'($urandom); x1_i = CB'($urandom); y1_i = CB'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: every write or done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (we_o === 1'b1 || done_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d we=%0d done=%0d x=%0d y=%0d", cyc, we_o, done_o,
                   addr_x_o, addr_y_o);
        end else begin
          e = exp_q.pop_front();
          if (e.dn) ok = done_o && !we_o && cyc == e.cy;
          else ok = we_o && !done_o && cyc == e.cy && int'(addr_x_o) == e.x &&
                    int'(addr_y_o) == e.y && int'(color_o) == e.c;
          if (!ok) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d we=%0d done=%0d x=%0d y=%0d c=%0d required dn=%0d cyc=%0d x=%0d y=%0d c=%0d",
                     cyc, we_o, done_o, addr_x_o, addr_y_o, color_o, e.dn, e.cy, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  initial begin
    int acc1;
    bit clr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_we", we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr_x", addr_x_o, 0);
    chk("rst_addr_y", addr_y_o, 0);
    chk("rst_color", color_o, 0);
    @(posedge clk); #1;
    rst = 0;

    send(0, 2, 3, 4, 4, 2, 0);
    send(0, 4, 4, 2, 3, 2, 0);
    send(0, 62, 46, 2000, 2000, 1, 0);
    send(0, 70, 5, 80, 9, 1, 0);
    send(1, 5, 5, 6, 6, 3, 0);
    drain();

    // Held valid: the second command must wait for the first IDLE cycle.
    send(0, 7, 7, 7, 7, 2, 1);
    acc1 = last_acc;
    send(0, 0, 0, 1, 0, 1, 0);
    chk("held_valid_accept_cycle", last_acc - acc1, 3);
    drain();

    // Reset during the 10th write of a 10x10 rectangle.
    send(0, 5, 5, 14, 14, 1, 0);
    while (cyc < last_acc + 9) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_we", we_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_addr_x", addr_x_o, 0);
    chk("abort_addr_y", addr_y_o, 0);
    chk("abort_color", color_o, 0);
    repeat (20) @(posedge clk);
    #1;
    send(0, 1, 1, 3, 2, 3, 0);
    drain();

    for (int i = 0; i < 20; i++) begin
      clr = ($urandom_range(0, 9) == 0);
      send(clr, $urandom_range(0, 80), $urandom_range(0, 60), $urandom_range(0, 80),
           $urandom_range(0, 60), $urandom_range(0, 3), 0);
    end
    drain();
    @(negedge clk);
    chk("final_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Drawing engine directly upstream of the VGA controller's video-buffer write port. Accepts rectangle-fill and clear-screen commands over a valid/ready handshake and emits one pixel write per clock (x, y, 2-bit colour, write enable) into the frame buffer. Normalises and clips coordinates to the display area, so the VGA stage never receives out-of-range addresses.

## Interface
- `HD`, 1280: display width in pixels; legal x is 0..HD-1
- `VD`, 1024: display height in pixels; legal y is 0..VD-1
- `COORD_BITS`, 11: width of every coordinate bus
- `clk`  in  1  system clock, same clock as the VGA controller
- `rst`  in  1  reset; synchronous, active-high
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  engine can accept a command (high only in IDLE)
- `cmd_clear_i`  in  1  1 = fill the whole screen, coordinates ignored
- `x0_i`, `y0_i`, `x1_i`, `y1_i`  in  COORD_BITS each  opposite corners, inclusive
- `color_i`  in  2  colour code: 0 black, 1 white, 2 blue, 3 green
- `we_o`  out  1  pixel write strobe, connects to the VGA `we_i`
- `addr_x_o`, `addr_y_o`  out  COORD_BITS each  pixel address
- `color_o`  out  2  pixel colour
- `busy_o`  out  1  a command is in progress
- `done_o`  out  1  one-cycle pulse after the last write of a command

## Operation
- A command is accepted when `cmd_valid_i & cmd_ready_o` are both high on a rising edge. On acceptance all command fields are registered and later input changes are ignored.
- Normalisation at accept: xa=min(x0,x1), xb=max(x0,x1); ya and yb are computed the same way.
- Clipping: xb=min(xb,HD-1), yb=min(yb,VD-1). If xa>HD-1 or ya>VD-1, the command is empty.
- Clear command: xa=0, ya=0, xb=HD-1, yb=VD-1, using `color_i`.
- FSM states:
  - IDLE: `cmd_ready_o`=1. On accept, go to FILL, or to DONE if the command is empty.
  - FILL: `we_o`=1 every cycle. Scan is row-major with x incrementing fastest. At x==xb, x reloads xa and y increments. At x==xb and y==yb, go to DONE.
  - DONE: `done_o`=1 for one cycle, then go to IDLE.
- `busy_o` = (state != IDLE).
- `addr_x_o`, `addr_y_o` and `color_o` are registered and hold their last value outside FILL. Their value is don't-care when `we_o`=0.
- Compare on the full COORD_BITS width. Counters never wrap; the clip guarantees xb<HD and yb<VD.
- Degenerate rectangles (x0==x1 and/or y0==y1) produce exactly one row, one column or one pixel.
- Pixel count per command = (xb-xa+1)*(yb-ya+1). A clear produces HD*VD writes.

## Timing
- Reset, while `rst` is high at a clock edge: state=IDLE, `cmd_ready_o`=1, `we_o`=0, `busy_o`=0, `done_o`=0, `addr_x_o`=0, `addr_y_o`=0, `color_o`=0.
- Reset mid-FILL aborts the command immediately. There are no further writes and no `done_o`.
- Accept at edge N:
  - `we_o` is first high in cycle N+1, at (xa,ya).
  - The last write is in cycle N+P, where P is the pixel count.
  - `done_o` is high in cycle N+P+1.
  - `cmd_ready_o` is high again in cycle N+P+2.
- Empty command accepted at edge N: `done_o` is high in cycle N+1 and no writes occur.
- Throughput is one pixel per clock with no bubbles between rows.
- Minimum command-to-command spacing is P+2 cycles.
- `cmd_valid_i` held high during busy is not accepted. It is taken on the first IDLE cycle.

## Test plan
- After reset, rect (2,3)-(4,4) colour 2 → 6 writes in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4) in cycles N+1..N+6, all colour 2; `done_o` at N+7; `cmd_ready_o` at N+8.
- Swapped corners (4,4)-(2,3) → write sequence identical to the previous case.
- Clip: (1278,1022)-(2000,2000) colour 1 → writes (1278,1022)(1279,1022)(1278,1023)(1279,1023) only; fully outside (1300,5)-(1400,9) → zero writes, `done_o` at N+1.
- Clear with colour 3 → exactly 1,310,720 writes covering every (x,y) once; last write at (1279,1023); `done_o` the next cycle.
- Single pixel (7,7)-(7,7) with `cmd_valid_i` held high and the next command queued → one write; the second command is accepted at the first IDLE cycle, not earlier.
- Assert `rst` for 1 cycle during the 10th write of a 100-pixel rectangle → `we_o` is 0 from the next cycle, no `done_o`, all outputs at reset values, and a new command is accepted normally afterwards.
